// File: rtl/axil_ram_if.sv
// AXI4-Lite channel bundle for axil_ram: aw/w/b/ar/r signals with master and slave views.
interface axil_ram_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddress;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddress;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddress, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddress, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_ram.sv
// AXI4-Lite word RAM with byte strobes, independent read/write FSMs and READ_LATENCY wait cycles.
// Optional macro AXIL_RAM_RANGE_CHECK_EN: out-of-range addresses answer SLVERR instead of wrapping.
module axil_ram #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    axil_ram_if.slave   bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [3:0]  LAT    = 4'(READ_LATENCY);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic       {W_IDLE, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    logic [31:0] mem [DEPTH];

    logic        en_q;
    w_state_e    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q,  w_held_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [1:0]  bresp_q,   bresp_d;

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    logic        aw_hs, w_hs, ar_hs;
    logic        mem_we;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strb;
    logic        wr_oor, rd_oor;
    logic        unused_bits;

    assign bus.awready = en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign bus.wready  = en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.arready = en_q && (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    // A handshake in the committing cycle bypasses its hold register.
    assign wr_addr = aw_hs ? bus.awaddress : aw_addr_q;
    assign wr_data = w_hs  ? bus.wdata     : wdata_q;
    assign wr_strb = w_hs  ? bus.wstrb     : wstrb_q;
    assign rd_addr = (r_state_q == R_IDLE) ? bus.araddress : ar_addr_q;

`ifdef AXIL_RAM_RANGE_CHECK_EN
    assign wr_oor = |wr_addr[31:AW+2];
    assign rd_oor = |rd_addr[31:AW+2];
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    assign unused_bits = ^{bus.awprot, bus.arprot, wr_addr[1:0], rd_addr[1:0],
                           wr_addr[31:AW+2], rd_addr[31:AW+2]};

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = bus.awaddress;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
                    wstrb_d  = bus.wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    mem_we    = !wr_oor;
                    bresp_d   = wr_oor ? SLVERR : OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Memory is sampled on the edge entering R_RESP; a write on that edge is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        cnt_d     = cnt_q;
        ar_addr_d = ar_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_addr_d = bus.araddress;
                    if (LAT == 4'd0) begin
                        r_state_d = R_RESP;
                        rdata_d   = rd_oor ? 32'd0 : mem[rd_addr[AW+1:2]];
                        rresp_d   = rd_oor ? SLVERR : OKAY;
                    end else begin
                        cnt_d     = LAT;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (cnt_q == 4'd1) begin
                    r_state_d = R_RESP;
                    rdata_d   = rd_oor ? 32'd0 : mem[rd_addr[AW+1:2]];
                    rresp_d   = rd_oor ? SLVERR : OKAY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (bus.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q      <= 1'b0;
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bresp_q   <= OKAY;
            r_state_q <= R_IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= OKAY;
        end else begin
            en_q      <= 1'b1;
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Hold registers carry data only; their held flags qualify them.
    always_ff @(posedge clk) begin
        aw_addr_q <= aw_addr_d;
        wdata_q   <= wdata_d;
        wstrb_q   <= wstrb_d;
        ar_addr_q <= ar_addr_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_addr[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axil_ram.sv
// Bench for axil_ram: directed vector table, multi-cycle corner sequences and randomized
// traffic against an array-based memory model.
module tb_axil_ram;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;
    localparam int HI    = $clog2(DEPTH) + 2;
`ifdef AXIL_RAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    axil_ram_if bus();

    axil_ram #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_mem [DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        if (RC && ((a >> HI) != 0)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int i = 0; i < 4; i++)
                if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        if (RC && ((a >> HI) != 0)) begin
            d = 32'd0;
            resp = 2'b10;
        end else begin
            d = model_mem[int'((a >> 2) % DEPTH)];
            resp = 2'b00;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int lat);
        int c;
        bit aw_done, w_done, aw_hs, w_hs;
        c = 0; aw_done = 0; w_done = 0;
        bus.awaddress = a; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done) && c < 60) begin
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            c++;
            aw_done |= aw_hs;
            w_done  |= w_hs;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        chk("wr_handshakes", 32'(aw_done && w_done), 32'd1);
        lat = 0;
        while (!bus.bvalid && lat < 50) begin tick(); lat++; end
        repeat (b_dly) tick();
        resp = bus.bresp;
        bus.bready = 1; tick(); bus.bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly,
                            output logic [31:0] d, output logic [1:0] resp, output int lat);
        int c;
        c = 0;
        bus.arvalid = 1; bus.araddress = a;
        while (!bus.arready && c < 50) begin tick(); c++; end
        chk("rd_ar_accept", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 0;
        lat = 0;
        while (!bus.rvalid && lat < 50) begin tick(); lat++; end
        repeat (r_dly) tick();
        d = bus.rdata; resp = bus.rresp;
        bus.rready = 1; tick(); bus.rready = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, ed, a;
        logic [1:0]  r, er;
        int          lat;

        bus.awvalid = 0; bus.awaddress = 0; bus.awprot = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddress = 0; bus.arprot = 0; bus.rready = 0;

        vecs.push_back('{1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h10,   32'h0, 4'h0, 32'hDEADBEEF, 2'b00});
        vecs.push_back('{1, 32'h14,   32'hFFFFFFFF, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1, 32'h14,   32'h12345678, 4'h5, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h14,   32'h0, 4'h0, 32'hFF34FF78, 2'b00});
        vecs.push_back('{1, 32'h18,   32'h0BADF00D, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{1, 32'h18,   32'hCAFEF00D, 4'h0, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h18,   32'h0, 4'h0, 32'h0BADF00D, 2'b00});
        vecs.push_back('{1, 32'h00,   32'hA5A5A5A5, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'h1000, 32'h0, 4'h0, RC ? 32'h0 : 32'hA5A5A5A5, RC ? 2'b10 : 2'b00});
        vecs.push_back('{1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'h0, RC ? 2'b10 : 2'b00});
        vecs.push_back('{0, 32'h00,   32'h0, 4'h0, RC ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 2'b00});
        vecs.push_back('{1, 32'hFFC,  32'h87654321, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{0, 32'hFFF,  32'h0, 4'h0, 32'h87654321, 2'b00});

        // Reset state and release
        repeat (3) tick();
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready",  bus.wready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid",  bus.bvalid, 0);
        chk("rst_rvalid",  bus.rvalid, 0);
        chk("rst_bresp",   bus.bresp, 0);
        chk("rst_rresp",   bus.rresp, 0);
        chk("rst_rdata",   bus.rdata, 0);
        reset = 1;
        #1;
        chk("rel_awready_before_edge", bus.awready, 0);
        tick();
        chk("rel_awready", bus.awready, 1);
        chk("rel_wready",  bus.wready, 1);
        chk("rel_arready", bus.arready, 1);
        chk("rel_bvalid",  bus.bvalid, 0);
        chk("rel_rvalid",  bus.rvalid, 0);

        // Directed vector table
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, r, lat);
                chk($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
                chk($sformatf("vec%0d_blat", i), lat, 0);
            end else begin
                axi_read(vecs[i].addr, 0, d, r, lat);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rlat", i), lat, RL);
            end
        end

        // W before AW, merging one byte over 0xDEADBEEF at 0x10
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat);
        bus.wvalid = 1; bus.wdata = 32'h000000AA; bus.wstrb = 4'b0001;
        tick();
        bus.wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("wfirst_wready_held", bus.wready, 0);
            chk("wfirst_no_bvalid", bus.bvalid, 0);
            chk("wfirst_awready", bus.awready, 1);
            tick();
        end
        bus.awvalid = 1; bus.awaddress = 32'h10;
        tick();
        bus.awvalid = 0;
        chk("wfirst_bvalid", bus.bvalid, 1);
        chk("wfirst_bresp", bus.bresp, 0);
        chk("wfirst_wready_resp", bus.wready, 0);
        tick();
        chk("wfirst_wready_bp", bus.wready, 0);
        bus.bready = 1; tick(); bus.bready = 0;
        chk("wfirst_wready_after_b", bus.wready, 1);
        axi_read(32'h10, 0, d, r, lat);
        chk("wfirst_readback", d, 32'hDEADBEAA);

        // Backpressure on both response channels
        bus.awvalid = 1; bus.awaddress = 32'h40;
        bus.wvalid = 1; bus.wdata = 32'h40404040; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddress = 32'h10;
        tick();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        repeat (RL) tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid", bus.bvalid, 1);
            chk("bp_rvalid", bus.rvalid, 1);
            chk("bp_rdata", bus.rdata, 32'hDEADBEAA);
            chk("bp_bresp", bus.bresp, 0);
            chk("bp_rresp", bus.rresp, 0);
            chk("bp_awready", bus.awready, 0);
            chk("bp_arready", bus.arready, 0);
            tick();
        end
        bus.bready = 1; bus.rready = 1;
        tick();
        bus.bready = 0; bus.rready = 0;
        chk("bp_bvalid_done", bus.bvalid, 0);
        chk("bp_rvalid_done", bus.rvalid, 0);
        chk("bp_awready_back", bus.awready, 1);
        chk("bp_arready_back", bus.arready, 1);
        axi_read(32'h40, 0, d, r, lat);
        chk("bp_write_landed", d, 32'h40404040);

        // Read sampling edge coincides with write commit edge
        axi_write(32'h20, 32'h11111111, 4'hF, 0, 0, 0, r, lat);
        bus.awvalid = 1; bus.awaddress = 32'h20;
        tick();
        bus.awvalid = 0;
        bus.arvalid = 1; bus.araddress = 32'h20;
        bus.wdata = 32'h22222222; bus.wstrb = 4'hF;
        if (RL == 0) bus.wvalid = 1;
        tick();
        bus.arvalid = 0;
        if (RL > 0) begin
            repeat (RL - 1) tick();
            bus.wvalid = 1;
            tick();
        end
        bus.wvalid = 0;
        chk("rdw_rvalid", bus.rvalid, 1);
        chk("rdw_bvalid", bus.bvalid, 1);
        chk("rdw_old_data", bus.rdata, 32'h11111111);
        bus.rready = 1; bus.bready = 1; tick(); bus.rready = 0; bus.bready = 0;
        axi_read(32'h20, 0, d, r, lat);
        chk("rdw_new_data", d, 32'h22222222);

        // Reset during R_WAIT with an uncommitted AW held
        axi_write(32'h30, 32'h30303030, 4'hF, 0, 0, 0, r, lat);
        bus.awvalid = 1; bus.awaddress = 32'h30;
        bus.arvalid = 1; bus.araddress = 32'h24;
        tick();
        bus.awvalid = 0; bus.arvalid = 0;
        reset = 0;
        #1;
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_arready", bus.arready, 0);
        chk("mid_rst_awready", bus.awready, 0);
        tick();
        reset = 1;
        #1;
        chk("mid_rel_arready_low", bus.arready, 0);
        tick();
        chk("mid_rel_arready", bus.arready, 1);
        chk("mid_rel_awready", bus.awready, 1);
        chk("mid_rel_rvalid", bus.rvalid, 0);
        bus.wvalid = 1; bus.wdata = 32'h99999999; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 0;
        tick();
        chk("mid_no_stale_aw", bus.bvalid, 0);
        bus.awvalid = 1; bus.awaddress = 32'h34;
        tick();
        bus.awvalid = 0;
        chk("mid_commit_bvalid", bus.bvalid, 1);
        bus.bready = 1; tick(); bus.bready = 0;
        axi_read(32'h30, 0, d, r, lat);
        chk("mid_lost_write", d, 32'h30303030);
        axi_read(32'h34, 0, d, r, lat);
        chk("mid_new_write", d, 32'h99999999);

        // Randomized traffic against the model
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            axi_write(32'(w * 4), d, 4'hF, 0, 0, 0, r, lat);
            model_write(32'(w * 4), d, 4'hF, er);
        end
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 255)) << HI;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), r, lat);
                model_write(a, d, bus.wstrb, er);
                chk($sformatf("rnd%0d_bresp@%08h", n, a), r, er);
                chk($sformatf("rnd%0d_blat", n), lat, 0);
            end else begin
                axi_read(a, $urandom_range(0, 2), d, r, lat);
                model_read(a, ed, er);
                chk($sformatf("rnd%0d_rdata@%08h", n, a), d, ed);
                chk($sformatf("rnd%0d_rresp", n), r, er);
                chk($sformatf("rnd%0d_rlat", n), lat, RL);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axil_ram.md
# axil_ram

AXI4-Lite responder (slave) memory answering the core's instruction and data bus. It provides word-organised RAM with byte-strobe writes, independent read and write channels, and programmable read latency. It sits on the far side of the core's aw/w/b/ar/r channels in simulation and formal benches, and serves as the on-chip RAM in synthesis builds.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, minimum 4.
- READ_LATENCY, 0: extra wait cycles between AR handshake and rvalid, range 0–15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- awvalid  input  1  write address valid.
- awready  output  1  write address accepted.
- awaddress  input  32  byte address; bits [1:0] ignored.
- awprot  input  3  ignored.
- wvalid  input  1  write data valid.
- wready  output  1  write data accepted.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
- bvalid  output  1  write response valid.
- bready  input  1  write response accepted.
- bresp  output  2  00 OKAY, 10 SLVERR.
- arvalid  input  1  read address valid.
- arready  output  1  read address accepted.
- araddress  input  32  byte address; bits [1:0] ignored.
- arprot  input  3  ignored.
- rvalid  output  1  read data valid.
- rready  input  1  read data accepted.
- rdata  output  32  read data.
- rresp  output  2  00 OKAY, 10 SLVERR.

## Operation
- Word index = address[log2(DEPTH)+1:2].
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are accepted independently and in either order, including the same cycle. Each is latched into a hold register with a held flag.
  - awready = W_IDLE and no AW held. wready = W_IDLE and no W held.
  - The edge completing the second handshake, or both in the same cycle, commits the write. Only strobed bytes are written. The FSM enters W_RESP.
  - W_RESP: bvalid=1, with bresp stable until bready. On that handshake the held flags clear and the FSM returns to W_IDLE.
  - wstrb=0000 is a legal write: memory is unchanged and bresp=OKAY.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - arready = R_IDLE.
  - AR handshake latches the address. With READ_LATENCY=0 the FSM goes to R_RESP; otherwise it goes to R_WAIT with a counter of READ_LATENCY.
  - The memory word is sampled on the edge entering R_RESP.
  - R_RESP: rvalid=1, with rdata and rresp stable until rready. On that handshake the FSM returns to R_IDLE.
- Read and write channels are fully independent. Read-during-write to the same word on the same edge returns the old data.
- Outstanding transactions: at most one write and one read.
- Reset, asynchronous:
  - Both FSMs go idle and all held flags clear.
  - awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
  - Memory contents are not reset.
  - A registered enable flop (reset 0) gates all readys, so they rise at the first clk edge after reset deasserts.
  - Reset mid-transaction abandons it: an uncommitted write is lost, and a committed write remains in memory.

## Timing
- Readys: high from the cycle after the first post-reset edge while the channel is idle.
- Write: the last AW/W handshake is at edge N, so memory is updated at edge N and bvalid is high from cycle N+1.
- Read: AR handshake at edge N, so rvalid is high from cycle N+1+READ_LATENCY.
- Back-to-back: a new AR is accepted the cycle after the R handshake. Peak rate is one read per 2 cycles at READ_LATENCY=0; writes are identical.
- Backpressure: bvalid and rvalid hold indefinitely while bready or rready is low, and the outputs do not change.

## Configuration
- AXIL_RAM_RANGE_CHECK_EN defined:
  - An address with any bit set at or above bit log2(DEPTH)+2 is out of range.
  - An out-of-range write leaves memory unchanged and returns bresp=10.
  - An out-of-range read returns rdata=0 and rresp=10.
- Undefined: upper address bits are ignored, addresses wrap modulo DEPTH*4, and responses are always 00.

## Test plan
- Reset release: after two edges with reset=1, awready=wready=arready=1 and bvalid=rvalid=0. Assert reset mid-R_WAIT: rvalid=0 immediately, arready returns 1 after release.
- Same-cycle AW+W: address 0x10, data 0xDEADBEEF, strobe 1111 gives bvalid next cycle with bresp=00. A later read of 0x10 returns 0xDEADBEEF after 1+READ_LATENCY cycles.
- W before AW: wdata 0x000000AA, wstrb 0001 three cycles before AW 0x10. Over prior 0xDEADBEEF, a read returns 0xDEADBEAA. wready stays 0 until B completes.
- Backpressure: hold bready=0 and rready=0 for 5 cycles. bvalid, rvalid, rdata and resp stay stable, and awready and arready stay 0 until the handshakes.
- Read-during-write: AR 0x20 and the final W commit to 0x20 on the same edge, with old 0x11111111 and new 0x22222222. The read returns 0x11111111 and the next read returns 0x22222222.
- With AXIL_RAM_RANGE_CHECK_EN, DEPTH=1024: write 0x00001000 gives bresp=10 and word 0 is unchanged. Read 0x00001000 gives rdata=0 and rresp=10. Without the macro, the same read returns word 0 with rresp=00.
